// File: rtl/bf16_unpack_norm.sv
// bfloat16 unpack/classify stage: valid/ready in, normalized significand + signed exponent out.
// Optional macro BF16_SUBNORM_EN enables iterative subnormal normalization (otherwise subnormals flush to ZERO).
//
// state  | meaning
// IDLE   | ready for a new word (in_ready = 1)
// NORM   | shifting a subnormal significand left one bit per cycle
// HOLD   | result presented (out_valid = 1) until out_ready
module bf16_unpack_norm #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [2:0]       out_class
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_HOLD} state_t;

  localparam logic [2:0] C_NORMAL = 3'd0;
  localparam logic [2:0] C_ZERO   = 3'd1;
  localparam logic [2:0] C_INF    = 3'd2;
  localparam logic [2:0] C_NAN    = 3'd3;
  localparam logic [2:0] C_NEG    = 3'd4;

  localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] ONE_E  = EXP_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mant;
  logic [EXP_W-1:0] r_exp;
  logic [2:0]       r_class;

  logic             w_sign;
  logic [7:0]       w_exp_f;
  logic [6:0]       w_frac;
  logic [2:0]       w_class;
  logic [7:0]       w_mant;
  logic [EXP_W-1:0] w_exp;
`ifdef BF16_SUBNORM_EN
  logic             w_to_norm;
`endif

  assign w_sign  = in_data[15];
  assign w_exp_f = in_data[14:7];
  assign w_frac  = in_data[6:0];

  // Classification priority: NaN, zero (incl. -0), negative, inf, subnormal, normal.
  always_comb begin
    w_class = C_NORMAL;
    w_mant  = {1'b1, w_frac};
    w_exp   = EXP_W'({1'b0, w_exp_f}) - BIAS_E;
`ifdef BF16_SUBNORM_EN
    w_to_norm = 1'b0;
`endif
    if (w_exp_f == 8'hFF && w_frac != 7'd0) begin
      w_class = C_NAN;
      w_mant  = 8'h00;
      w_exp   = '0;
    end else if (w_exp_f == 8'h00 && w_frac == 7'd0) begin
      w_class = C_ZERO;
      w_mant  = 8'h00;
      w_exp   = '0;
    end else if (w_sign) begin
      w_class = C_NEG;
      w_mant  = 8'h00;
      w_exp   = '0;
    end else if (w_exp_f == 8'hFF) begin
      w_class = C_INF;
      w_mant  = 8'h00;
      w_exp   = '0;
    end else if (w_exp_f == 8'h00) begin
`ifdef BF16_SUBNORM_EN
      w_class   = C_NORMAL;
      w_mant    = {1'b0, w_frac};
      w_exp     = ONE_E - BIAS_E;
      w_to_norm = 1'b1;
`else
      w_class = C_ZERO;
      w_mant  = 8'h00;
      w_exp   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef BF16_SUBNORM_EN
          w_state_nxt = w_to_norm ? S_NORM : S_HOLD;
`else
          w_state_nxt = S_HOLD;
`endif
        end
      end
      S_NORM: begin
`ifdef BF16_SUBNORM_EN
        // bit 6 becomes bit 7 on this shift, so leave now
        if (r_mant[6]) w_state_nxt = S_HOLD;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_HOLD: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant  <= 8'h00;
      r_exp   <= '0;
      r_class <= C_NORMAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mant  <= w_mant;
            r_exp   <= w_exp;
            r_class <= w_class;
          end
        end
`ifdef BF16_SUBNORM_EN
        S_NORM: begin
          r_mant <= r_mant << 1;
          r_exp  <= r_exp - ONE_E;
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign out_mant  = r_mant;
  assign out_exp   = r_exp;
  assign out_class = r_class;

endmodule

// File: tb/tb_bf16_unpack_norm.sv
// Randomized + directed bench for bf16_unpack_norm against a value-level bfloat16 reference model.
// Model follows BF16_SUBNORM_EN the same way the build does.
module tb_bf16_unpack_norm;

  localparam int EXP_W = 9;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [2:0]       out_class;

  int n_checks = 0;
  int n_errors = 0;

  bf16_unpack_norm #(.BIAS(127), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_class (out_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp_v, exp_v, $time);
    end
  endtask

  // Reference: classify by value; subnormals normalized by doubling until >= 128.
  function automatic void ref_model(input logic [15:0] w, output int cls, output int mant,
                                    output int ex, output int lat);
    int s, e, f, m, l;
    s = int'(w[15]);
    e = int'(w[14:7]);
    f = int'(w[6:0]);
    mant = 0; ex = 0; lat = 1; cls = 0;
    if (e == 255 && f != 0)      cls = 3;
    else if (e == 0 && f == 0)   cls = 1;
    else if (s == 1)             cls = 4;
    else if (e == 255)           cls = 2;
    else if (e == 0) begin
`ifdef BF16_SUBNORM_EN
      m = f; l = 0;
      while (m < 128) begin m = m * 2; l++; end
      cls = 0; mant = m; ex = -126 - l; lat = 1 + l;
`else
      cls = 1;
`endif
    end else begin
      cls = 0; mant = 128 + f; ex = e - 127;
    end
  endfunction

  function automatic int sexp();
    logic signed [EXP_W-1:0] t;
    t = out_exp;
    return int'(t);
  endfunction

  task automatic run_word(input logic [15:0] w);
    int cls, mant, ex, lat, cyc;
    ref_model(w, cls, mant, ex, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    out_ready = 1'b0;
    chk("in_ready_before_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency_%04h", w), cyc, lat);
    chk($sformatf("class_%04h", w), int'(out_class), cls);
    chk($sformatf("mant_%04h", w), int'(out_mant), mant);
    chk($sformatf("exp_%04h", w), sexp(), ex);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handoff", int'(out_valid), 0);
    chk("in_ready_after_handoff", int'(in_ready), 1);
  endtask

  logic [15:0] directed [10] = '{16'h3F80, 16'h4040, 16'h7F80, 16'h7FC0, 16'hFFC0,
                                 16'hBF80, 16'h8000, 16'h0000, 16'h0040, 16'h0001};

  initial begin
    logic [15:0] w;
    int r;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_mant", int'(out_mant), 0);
    chk("reset_exp", sexp(), 0);
    chk("reset_class", int'(out_class), 0);
    // a word offered during reset must not be taken
    in_valid = 1'b1; in_data = 16'h3F80;
    repeat (3) @(posedge clk);
    #1;
    chk("no_transfer_in_reset", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    foreach (directed[i]) run_word(directed[i]);

    // backpressure: first result held while a second word waits
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h3F80; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h4040;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_mant", int'(out_mant), 8'h80);
      chk("bp_exp", sexp(), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_valid", int'(out_valid), 1);
    chk("bp_second_mant", int'(out_mant), 8'hC0);
    chk("bp_second_exp", sexp(), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset while a subnormal is in flight (NORM, or HOLD when flushed)
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_mant", int'(out_mant), 0);
    chk("midrst_exp", sexp(), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("midrst_no_result", int'(out_valid), 0);
    end
    run_word(16'h3F80);

    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      r = int'($urandom_range(0, 7));
      if (r < 2)       w[14:7] = 8'h00;
      else if (r == 2) w[14:7] = 8'hFF;
      run_word(w);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bf16_unpack_norm.md
# bf16_unpack_norm

Input-side stage of the bfloat16 log datapath. Accepts raw bfloat16 words over a valid/ready handshake and classifies each one as normal, zero, infinity, NaN or negative. Finite positive operands are delivered as an 8-bit normalized significand plus a signed unbiased exponent. The 8-bit significand feeds the 8-bit `initial_value` operand of the downstream power/division core; subnormals are normalized iteratively, one bit per cycle.

## Interface
Parameters:
- `BIAS`, default 127: exponent bias subtracted from the biased exponent field.
- `EXP_W`, default 9: width of `out_exp`; signed two's complement; must be ≥ 9.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word; high only in IDLE.
- `in_data`  in  16: bfloat16 word `{sign, exp[7:0], frac[6:0]}`.
- `out_valid`  out  1: result is held on the outputs.
- `out_ready`  in  1: downstream accepts the result.
- `out_mant`  out  8: significand `1.fffffff`; bit 7 = 1 for class NORMAL.
- `out_exp`  out  `EXP_W`: unbiased exponent, signed.
- `out_class`  out  3: 0 NORMAL, 1 ZERO, 2 INF, 3 NAN, 4 NEG.

## Operation
- FSM states: IDLE, NORM, HOLD. Reset state is IDLE.
- IDLE: `in_ready` = 1. An input transfer occurs when `in_valid` and `in_ready` are both high at a clock edge.
- Classification on transfer, in priority order:
  - exp = 255 and frac ≠ 0: NAN.
  - exp = 0 and frac = 0: ZERO. This includes −0.
  - sign = 1: NEG.
  - exp = 255: INF.
  - exp = 0: subnormal path.
  - Otherwise: NORMAL.
- Special classes (NAN, ZERO, NEG, INF): `out_mant` = 0, `out_exp` = 0. Next state is HOLD.
- NORMAL: `out_mant` = `{1, frac}`, `out_exp` = exp − `BIAS`. Next state is HOLD.
- Subnormal path: working mant = `{0, frac}`, working exp = 1 − `BIAS`. Next state is NORM.
- NORM, each cycle: shift mant left by 1 and decrement exp by 1. Move to HOLD in the same cycle the shifted mant has bit 7 = 1. Class is NORMAL.
- For frac with L leading zeros counted over the 8-bit `{0, frac}`, L ranges 1..7, and the final exp is −126 − L. The minimum exponent is −133.
- HOLD: `out_valid` = 1 and all outputs are held stable. If `out_ready` = 1 at the edge, return to IDLE. There is no IDLE bypass, so the peak throughput is one word per 2 cycles.
- `in_ready` is 0 in NORM and HOLD. `in_valid` in those states is ignored, and the upstream producer must keep its word.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_mant` 0x00, `out_exp` 0, `out_class` 0.
- While `rst` is high, the flops stay cleared and no transfer takes place, even though `in_ready` reads 1.
- Accept at edge T, normal or special word: `out_valid` is high from T+1.
- Accept at edge T, subnormal word: L cycles in NORM, then `out_valid` is high from T+1+L.
- Result leaves at the first edge where `out_valid` and `out_ready` are both high. The next accept can occur no earlier than the following edge.
- `rst` asserted mid-NORM or mid-HOLD: the in-flight word is discarded, and outputs are at reset values immediately (asynchronous).
- `out_ready` high outside HOLD has no effect.

## Configuration
- `BF16_SUBNORM_EN` defined: the subnormal path works as described above, with variable latency 1+L.
- `BF16_SUBNORM_EN` undefined:
  - Subnormals (exp = 0, frac ≠ 0, sign = 0) flush to class ZERO with `out_mant` = 0 and `out_exp` = 0.
  - Latency is 1 for all inputs.
  - The NORM state and its shifter are not synthesized.
  - Negative subnormals still report NEG.

## Test plan
- 1.0 and 3.0: `in_data` 0x3F80 → NORMAL, `out_mant` 0x80, `out_exp` 0, `out_valid` one cycle after accept. `in_data` 0x4040 → `out_mant` 0xC0, `out_exp` 1.
- Specials:
  - 0x7F80 → INF.
  - 0x7FC0 → NAN.
  - 0xFFC0 → NAN.
  - 0xBF80 → NEG.
  - 0x8000 → ZERO.
  - 0x0000 → ZERO.
  - All with `out_mant` = 0 and `out_exp` = 0.
- Subnormals with the macro defined: 0x0040 → `out_mant` 0x80, `out_exp` −127 (0x181), `out_valid` at T+2. 0x0001 → `out_mant` 0x80, `out_exp` −133 (0x17B), `out_valid` at T+8.
- Subnormals without the macro: 0x0001 → ZERO at T+1.
- Backpressure: hold `out_ready` low for 5 cycles after a result on 0x3F80. Outputs must stay stable and `in_ready` must stay 0, with a second word 0x4040 waiting. Release `out_ready`: 0x3F80 completes, then 0x4040 is accepted on the next edge.
- Reset mid-operation: assert `rst` during NORM of 0x0001. `out_valid` goes to 0 immediately and no result appears. After deassert, `in_ready` = 1 and 0x3F80 processes normally.
